spi_reg_ctrl: RTL and testbench

Register-access controller behind `SPI_slave` (BITS=8). It turns pairs of SPI frames into single-word reads and writes on a simple req/ack register bus. Frame 1 is a command byte: bit7 = read(1)/write(0), bits[6:0] = address. Frame 2 carries the write data, or returns the read data. It drives `data_from_slave` so the byte the slave loads at the next csn fall is always defined.

---
 rtl/spi_reg_ctrl_pkg.sv | 27 ++
 rtl/spi_reg_ctrl_timer.sv | 27 ++
 rtl/spi_reg_ctrl.sv | 141 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register-access controller.
// The SPI_REG_CTRL_TIMEOUT_EN build option is handled in spi_reg_ctrl.sv.
package spi_reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS_RD = 2'd1,
        ST_DATA   = 2'd2,
        ST_BUS_WR = 2'd3
    } state_t;

    localparam logic [7:0] STATUS_BASE = 8'hA0;
    localparam logic [7:0] NOT_READY   = 8'hEE;
    localparam int         CMD_RD_BIT  = 7;

    localparam int TIMEOUT = 0;
    localparam int OVERRUN = 1;

    function automatic logic [7:0] status_byte(input logic overrun_f, input logic timeout_f);
        logic [7:0] s;
        s          = STATUS_BASE;
        s[OVERRUN] = overrun_f;
        s[TIMEOUT] = timeout_f;
        return s;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_timer.sv
// Clear/enable/expire counter bounding how long the controller waits for a data frame.
// Only instantiated when SPI_REG_CTRL_TIMEOUT_EN is defined.
module spi_reg_ctrl_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns command/data SPI frame pairs into single-word req/ack register bus accesses.
// Define SPI_REG_CTRL_TIMEOUT_EN to abandon a command whose data frame never arrives.
module spi_reg_ctrl #(
    parameter int BITS           = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ready,
    input  logic [BITS-1:0] data_from_master,
    output logic [BITS-1:0] data_from_slave,
    output logic            bus_req,
    output logic            bus_we,
    output logic [BITS-2:0] bus_addr,
    output logic [BITS-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [BITS-1:0] bus_rdata
);

    import spi_reg_ctrl_pkg::*;

    if (BITS != 8) begin : g_bits_check
        $error("spi_reg_ctrl: command byte layout requires BITS == 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("spi_reg_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_t          state_q, state_nxt;
    logic            ready_q;
    logic            fe;
    logic [BITS-1:0] cmd_q;
    logic            is_rd;
    logic            overrun_q, overrun_nxt;
    logic            timeout_q, timeout_nxt;
    logic [7:0]      status_nxt;
    logic            expired;

    assign fe       = ready & ~ready_q;
    assign is_rd    = cmd_q[CMD_RD_BIT];
    assign bus_addr = cmd_q[BITS-2:0];

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    spi_reg_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != ST_DATA),
        .en     (state_q == ST_DATA),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (fe) state_nxt = data_from_master[CMD_RD_BIT] ? ST_BUS_RD : ST_DATA;
            ST_BUS_RD: if (bus_ack) state_nxt = ST_DATA;
            ST_DATA: begin
                if (fe)           state_nxt = is_rd ? ST_IDLE : ST_BUS_WR;
                else if (expired) state_nxt = ST_IDLE;
            end
            ST_BUS_WR: if (bus_ack) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req = (state_q == ST_BUS_RD) || (state_q == ST_BUS_WR);
        bus_we  = (state_q == ST_BUS_WR);
    end

    // Sticky flags; the status byte is built from their next value so it is current on entry to IDLE
    always_comb begin
        overrun_nxt = overrun_q;
        timeout_nxt = timeout_q;
        if (state_q == ST_IDLE && fe) begin
            overrun_nxt = 1'b0;
            timeout_nxt = 1'b0;
        end
        if ((state_q == ST_BUS_RD || state_q == ST_BUS_WR) && fe) begin
            overrun_nxt = 1'b1;
        end
        if (state_q == ST_DATA && !fe && expired) begin
            timeout_nxt = 1'b1;
        end
        status_nxt = status_byte(overrun_nxt, timeout_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q         <= 1'b1;
            cmd_q           <= '0;
            bus_wdata       <= '0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
            data_from_slave <= STATUS_BASE;
        end else begin
            ready_q   <= ready;
            overrun_q <= overrun_nxt;
            timeout_q <= timeout_nxt;
            case (state_q)
                ST_IDLE: begin
                    if (fe) begin
                        cmd_q           <= data_from_master;
                        data_from_slave <= data_from_master[CMD_RD_BIT] ? NOT_READY : '0;
                    end else begin
                        data_from_slave <= status_nxt;
                    end
                end
                ST_BUS_RD: begin
                    if (bus_ack) data_from_slave <= bus_rdata;
                end
                ST_DATA: begin
                    if (fe) begin
                        if (is_rd) data_from_slave <= status_nxt;
                        else       bus_wdata       <= data_from_master;
                    end else if (expired) begin
                        data_from_slave <= status_nxt;
                    end
                end
                ST_BUS_WR: begin
                    if (bus_ack) data_from_slave <= status_nxt;
                end
                default: data_from_slave <= status_nxt;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: write, read, overrun, timeout/wait, reset, back-to-back.
// Covers both builds, with and without SPI_REG_CTRL_TIMEOUT_EN.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ready;
    logic [7:0] data_from_master;
    logic [7:0] data_from_slave;
    logic       bus_req;
    logic       bus_we;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] mem [128];

    spi_reg_ctrl #(
        .BITS          (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ready           (ready),
        .data_from_master(data_from_master),
        .data_from_slave (data_from_slave),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Host frame: miso is the byte loaded at csn fall; fe happens when ready rises again
    task automatic frame(input logic [7:0] mosi, input logic [7:0] exp_miso, input string tag);
        chk(tag, data_from_slave, exp_miso);
        ready            = 1'b0;
        data_from_master = mosi;
        tick(8);
        ready = 1'b1;
        tick(1);
    endtask

    task automatic ack(input logic [7:0] rd);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        tick(1);
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        rst_n = 1'b0; ready = 1'b1; data_from_master = 8'h00;
        bus_ack = 1'b0; bus_rdata = 8'h00;
        tick(3);
        chk("rst_req",   {7'b0, bus_req}, 8'h00);
        chk("rst_we",    {7'b0, bus_we},  8'h00);
        chk("rst_addr",  {1'b0, bus_addr}, 8'h00);
        chk("rst_wdata", bus_wdata, 8'h00);
        chk("rst_dfs",   data_from_slave, 8'hA0);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_req", {7'b0, bus_req}, 8'h00);

        // Write 0x3C to address 5, ack two cycles after request
        frame(8'h05, 8'hA0, "wr_f1");
        chk("wr_data_req", {7'b0, bus_req}, 8'h00);
        frame(8'h3C, 8'h00, "wr_f2");
        chk("wr_req",   {7'b0, bus_req}, 8'h01);
        chk("wr_we",    {7'b0, bus_we},  8'h01);
        chk("wr_addr",  {1'b0, bus_addr}, 8'h05);
        chk("wr_wdata", bus_wdata, 8'h3C);
        tick(1);
        chk("wr_hold_wdata", bus_wdata, 8'h3C);
        ack(8'h00);
        chk("wr_req_drop", {7'b0, bus_req}, 8'h00);
        chk("wr_status",   data_from_slave, 8'hA0);

        // Read address 5 returning 0x77 after three cycles
        tick(4);
        frame(8'h85, 8'hA0, "rd_f1");
        chk("rd_req",  {7'b0, bus_req}, 8'h01);
        chk("rd_we",   {7'b0, bus_we},  8'h00);
        chk("rd_addr", {1'b0, bus_addr}, 8'h05);
        chk("rd_busy", data_from_slave, 8'hEE);
        tick(2);
        ack(8'h77);
        chk("rd_req_drop", {7'b0, bus_req}, 8'h00);
        chk("rd_dfs",      data_from_slave, 8'h77);
        tick(10);
        frame(8'h00, 8'h77, "rd_f2");
        chk("rd_back_idle", data_from_slave, 8'hA0);

        // Overrun: second frame lands while the read is still outstanding
        frame(8'h85, 8'hA0, "ov_f1");
        tick(10);
        frame(8'h00, 8'hEE, "ov_f2");
        chk("ov_still_req", {7'b0, bus_req}, 8'h01);
        tick(30);
        ack(8'h5A);
        chk("ov_dfs", data_from_slave, 8'h5A);
        frame(8'h00, 8'h5A, "ov_f3");
        chk("ov_status", data_from_slave, 8'hA2);
        frame(8'h85, 8'hA2, "ov_f4_cmd");

        // Frame end coincident with ack: ack honoured, overrun flagged
        ready = 1'b0;
        tick(4);
        ready = 1'b1; bus_ack = 1'b1; bus_rdata = 8'h11;
        tick(1);
        bus_ack = 1'b0; bus_rdata = 8'h00;
        chk("co_req_drop", {7'b0, bus_req}, 8'h00);
        chk("co_dfs",      data_from_slave, 8'h11);
        frame(8'h00, 8'h11, "co_f2");
        chk("co_status", data_from_slave, 8'hA2);

        // Back-to-back: write 0xAA to address 2, then read it back through the bank model
        frame(8'h02, 8'hA2, "bb_wcmd");
        frame(8'hAA, 8'h00, "bb_wdata");
        chk("bb_waddr", {1'b0, bus_addr}, 8'h02);
        if (bus_req && bus_we) mem[bus_addr] = bus_wdata;
        ack(8'h00);
        frame(8'h82, 8'hA0, "bb_rcmd");
        tick(1);
        ack(mem[bus_addr]);
        frame(8'h00, 8'hAA, "bb_rdata");

        // Data frame withheld for 20 cycles
        frame(8'h01, 8'hA0, "to_cmd");
        tick(20);
        chk("to_no_req", {7'b0, bus_req}, 8'h00);
`ifdef SPI_REG_CTRL_TIMEOUT_EN
        chk("to_status", data_from_slave, 8'hA1);
        frame(8'h01, 8'hA1, "to_next_cmd");
        frame(8'h99, 8'h00, "to_wr_data");
`else
        chk("wait_dfs", data_from_slave, 8'h00);
        frame(8'h99, 8'h00, "wait_wr_data");
`endif
        chk("late_wr_req",   {7'b0, bus_req}, 8'h01);
        chk("late_wr_wdata", bus_wdata, 8'h99);

        // Reset mid bus cycle, then ready held high
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_req",   {7'b0, bus_req}, 8'h00);
        chk("mid_rst_dfs",   data_from_slave, 8'hA0);
        chk("mid_rst_wdata", bus_wdata, 8'h00);
        chk("mid_rst_addr",  {1'b0, bus_addr}, 8'h00);
        rst_n = 1'b1;
        tick(5);
        chk("mid_rst_noevt", {7'b0, bus_req}, 8'h00);
        ack(8'h33);
        chk("idle_ack_ignored", data_from_slave, 8'hA0);
        chk("idle_ack_req",     {7'b0, bus_req}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
